branch_pc_unit: RTL and testbench

- Fetch-side PC register plus ID-stage branch/jump resolution for the 5-stage MIPS core.
- Consumes the `neql` flag from the ID-stage register comparator, together with the decoded branch op, immediate/index and `rdata1`.
- Produces the fetch PC with a valid/ready handshake to instruction memory, an IF/ID flush pulse and the `jal` link write.

---
 rtl/branch_pc_unit.sv | 131 +++++++++++++
 tb/tb_branch_pc_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Fetch PC register with ID-stage branch/jump resolution and imem valid/ready request.
// A taken branch redirects fetch when its request is accepted; otherwise the target waits in PEND.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        if_ready,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [2:0]  br_op,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx,
  input  logic [31:0] rdata1,
  input  logic        neql,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        br_taken,
  output logic        link_we,
  output logic [31:0] link_addr
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_BNE = 3'b010;
  localparam logic [2:0] OP_J   = 3'b011;
  localparam logic [2:0] OP_JAL = 3'b100;
  localparam logic [2:0] OP_JR  = 3'b101;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        started_q;
  logic        req_hold_q, req_hold_d;

  logic        fire;
  logic        taken;
  logic        accepted;
  logic [31:0] id_pc4;
  logic [31:0] br_off;
  logic [31:0] target;

  assign fire   = id_valid & ~stall & ~rst;
  assign id_pc4 = id_pc + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = id_pc4 + br_off;
    case (br_op)
      OP_BEQ: taken = ~neql;
      OP_BNE: taken = neql;
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = {id_pc4[31:28], jidx, 2'b00};
      end
      OP_JR: begin
        taken  = 1'b1;
        target = rdata1;
      end
      default: taken = 1'b0;
    endcase
  end

  // A held request keeps pc_valid up through a stall so the imem sees a stable request.
  assign pc_valid  = started_q & (~stall | req_hold_q) & ~rst;
  assign accepted  = pc_valid & if_ready;
  assign br_taken  = fire & taken;
  assign link_we   = fire & (br_op == OP_JAL);
  assign link_addr = DELAY_SLOT ? (id_pc + 32'd8) : id_pc4;
  assign pc        = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'd0;
      started_q  <= 1'b0;
      req_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      started_q  <= 1'b1;
      req_hold_q <= req_hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (br_taken && !accepted) state_d = PEND;
      PEND:    if (accepted) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A second taken branch while in PEND is ignored; the first target wins.
  always_comb begin
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    flush      = 1'b0;
    req_hold_d = req_hold_q;
    if (accepted)      req_hold_d = 1'b0;
    else if (pc_valid) req_hold_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (br_taken && accepted) begin
          pc_d  = target;
          flush = ~DELAY_SLOT;
        end else if (br_taken) begin
          pend_tgt_d = target;
        end else if (accepted) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PEND: begin
        if (accepted) begin
          pc_d  = pend_tgt_q;
          flush = ~DELAY_SLOT;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, if_ready, id_valid, neql;
  logic [31:0] id_pc, rdata1;
  logic [2:0]  br_op;
  logic [15:0] imm16;
  logic [25:0] jidx;

  logic [31:0] pc1, pc0, la1, la0;
  logic        pv1, pv0, fl1, fl0, bt1, bt0, lw1, lw0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.RESET_PC(32'hBFC0_0000), .DELAY_SLOT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready), .id_valid(id_valid),
    .id_pc(id_pc), .br_op(br_op), .imm16(imm16), .jidx(jidx), .rdata1(rdata1),
    .neql(neql), .pc(pc1), .pc_valid(pv1), .flush(fl1), .br_taken(bt1),
    .link_we(lw1), .link_addr(la1)
  );

  branch_pc_unit #(.RESET_PC(32'hBFC0_0000), .DELAY_SLOT(1'b0)) u_dut_nods (
    .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready), .id_valid(id_valid),
    .id_pc(id_pc), .br_op(br_op), .imm16(imm16), .jidx(jidx), .rdata1(rdata1),
    .neql(neql), .pc(pc0), .pc_valid(pv0), .flush(fl0), .br_taken(bt0),
    .link_we(lw0), .link_addr(la0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [2:0] op, input logic [31:0] ipc, input logic [15:0] imm,
                        input logic [25:0] ji, input logic [31:0] rd1, input logic nq);
    id_valid = 1'b1;
    br_op    = op;
    id_pc    = ipc;
    imm16    = imm;
    jidx     = ji;
    rdata1   = rd1;
    neql     = nq;
  endtask

  task automatic check_pc(input string tag, input logic [31:0] exp);
    check({tag, "_pc"}, pc1, exp);
    check({tag, "_pc_nods"}, pc0, exp);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; if_ready = 1'b0;
    set_br(3'b100, 32'h0040_0020, 16'h0, 26'h100, 32'h0, 1'b0);
    if_ready = 1'b1;
    tick();
    #1;
    check("rst_pc_valid", {31'd0, pv1}, 32'd0);
    check("rst_pc", pc1, 32'hBFC0_0000);
    check("rst_br_taken", {31'd0, bt1}, 32'd0);
    check("rst_link_we", {31'd0, lw1}, 32'd0);
    check("rst_flush", {31'd0, fl0}, 32'd0);
    tick();
    rst = 1'b0; id_valid = 1'b0; br_op = 3'b000;
    #1;
    check("start_pc_valid", {31'd0, pv1}, 32'd0);
    tick();
    check_pc("seq0", 32'hBFC0_0000);
    check("seq0_valid", {31'd0, pv1}, 32'd1);
    tick();
    check_pc("seq1", 32'hBFC0_0004);
    tick();
    check_pc("seq2", 32'hBFC0_0008);

    // beq taken, backward offset
    set_br(3'b001, 32'hBFC0_0010, 16'hFFFE, 26'h0, 32'h0, 1'b0);
    #1;
    check("beq_taken", {31'd0, bt1}, 32'd1);
    check("beq_flush_ds", {31'd0, fl1}, 32'd0);
    check("beq_flush_nods", {31'd0, fl0}, 32'd1);
    tick();
    check_pc("beq", 32'hBFC0_000C);

    neql = 1'b1;
    #1;
    check("beq_nt_taken", {31'd0, bt1}, 32'd0);
    check("beq_nt_flush", {31'd0, fl0}, 32'd0);
    tick();
    check_pc("beq_nt", 32'hBFC0_0010);

    br_op = 3'b110;
    #1;
    check("op6_taken", {31'd0, bt1}, 32'd0);

    // bne while imem is not ready: target parks in PEND
    set_br(3'b010, 32'h0040_0000, 16'h0004, 26'h0, 32'h0, 1'b1);
    if_ready = 1'b0;
    #1;
    check("bne_taken", {31'd0, bt1}, 32'd1);
    check("bne_flush_nods", {31'd0, fl0}, 32'd0);
    tick();
    check_pc("bne_w1", 32'hBFC0_0010);
    id_valid = 1'b0; stall = 1'b1;
    #1;
    check("bne_hold_valid", {31'd0, pv1}, 32'd1);
    tick();
    check_pc("bne_w2", 32'hBFC0_0010);
    tick();
    check_pc("bne_w3", 32'hBFC0_0010);
    stall = 1'b0; if_ready = 1'b1;
    #1;
    check("pend_flush_nods", {31'd0, fl0}, 32'd1);
    check("pend_flush_ds", {31'd0, fl1}, 32'd0);
    tick();
    check_pc("bne", 32'h0040_0014);

    set_br(3'b100, 32'h0040_0020, 16'h0, 26'h000_0100, 32'h0, 1'b0);
    #1;
    check("jal_link_we", {31'd0, lw1}, 32'd1);
    check("jal_link_ds", la1, 32'h0040_0028);
    check("jal_link_nods", la0, 32'h0040_0024);
    tick();
    check_pc("jal", 32'h0000_0400);

    set_br(3'b101, 32'h0000_0400, 16'h0, 26'h0, 32'h0040_0028, 1'b0);
    #1;
    check("jr_link_we", {31'd0, lw1}, 32'd0);
    tick();
    check_pc("jr", 32'h0040_0028);

    // stall blocks resolution and fetch
    set_br(3'b001, 32'hBFC0_0010, 16'hFFFE, 26'h0, 32'h0, 1'b0);
    stall = 1'b1;
    #1;
    check("stall_taken", {31'd0, bt1}, 32'd0);
    check("stall_valid", {31'd0, pv1}, 32'd0);
    tick();
    check_pc("stall", 32'h0040_0028);
    stall = 1'b0;
    #1;
    check("unstall_taken", {31'd0, bt1}, 32'd1);
    tick();
    check_pc("unstall", 32'hBFC0_000C);

    set_br(3'b101, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
    tick();
    check_pc("jr_top", 32'hFFFF_FFFC);
    id_valid = 1'b0;
    tick();
    check_pc("wrap", 32'h0000_0000);

    // reset while a target is pending
    set_br(3'b001, 32'hBFC0_0010, 16'hFFFE, 26'h0, 32'h0, 1'b0);
    if_ready = 1'b0;
    tick();
    check_pc("pend_pre_rst", 32'h0000_0000);
    id_valid = 1'b0; rst = 1'b1;
    tick();
    check_pc("pend_rst", 32'hBFC0_0000);
    rst = 1'b0; if_ready = 1'b1;
    tick();
    #1;
    check("post_rst_flush", {31'd0, fl0}, 32'd0);
    tick();
    check_pc("post_rst", 32'hBFC0_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
